// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: parametrised UART transmitter with programmable bit period,
// optional parity, 1 or 2 stop bits and a one-deep holding register so that
// frames can run back to back.
//
// Ports:
//   clk, rst          system clock (rising edge), async active-low reset
//   p_data/data_valid word offered by the producer
//   data_ready        holding register empty; accept on data_valid & data_ready
//   par_en/par_type   parity enable, 0 = even / 1 = odd
//   stop2             two stop bits when 1
//   prescale          bit period = prescale + 1 clk cycles
//   tx_out            serial line (idles high)
//   busy              frame on the line
//   frame_done        one-cycle pulse after the last stop bit
module uart_tx_gen2 #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  p_data,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic                   par_en,
    input  logic                   par_type,
    input  logic                   stop2,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  hold_q;
    logic                   hold_full;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   par_bit;
    logic                   par_en_q;
    logic                   stop2_q;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic                   stop_cnt;

    logic bit_end;
    logic frame_end;
    logic load;

    // Bit-period boundary, end of last stop bit, and start of a new frame.
    assign bit_end   = (presc_cnt == presc_q);
    assign frame_end = (state == STOP) && bit_end && (!stop2_q || stop_cnt);
    assign load      = hold_full && ((state == IDLE) || frame_end);

    // Transmit FSM, holding register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            presc_q    <= '0;
            presc_cnt  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            data_ready <= 1'b1;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A load and an accept never coincide: load needs hold_full,
            // which keeps data_ready low for the whole cycle.
            if (load) begin
                hold_full  <= 1'b0;
                data_ready <= 1'b1;
            end else if (data_valid && data_ready) begin
                hold_q     <= p_data;
                hold_full  <= 1'b1;
                data_ready <= 1'b0;
            end

            if (frame_end) begin
                frame_done <= 1'b1;
            end

            if (load) begin
                // Latch word, parity and frame configuration for this frame.
                state     <= START;
                shreg     <= hold_q;
                par_bit   <= par_type ? ~^hold_q : ^hold_q;
                par_en_q  <= par_en;
                stop2_q   <= stop2;
                presc_q   <= prescale;
                presc_cnt <= '0;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                tx_out    <= 1'b0;
                busy      <= 1'b1;
            end else begin
                if (state != IDLE) begin
                    presc_cnt <= bit_end ? '0 : presc_cnt + 1'b1;
                end
                case (state)
                    IDLE: begin
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                                if (par_en_q) begin
                                    state  <= PARITY;
                                    tx_out <= par_bit;
                                end else begin
                                    state  <= STOP;
                                    tx_out <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_out  <= shreg[0];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (frame_end) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tx_out   <= 1'b1;
                            stop_cnt <= 1'b0;
                        end else if (bit_end) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2: directed self-checking bench for uart_tx_gen2 with an
// 8-bit and a 7-bit instance sharing the configuration inputs.
module tb_uart_tx_gen2;

    logic       clk_tb;
    logic       rst;
    logic [7:0] p8;
    logic [6:0] p7;
    logic       dv8, dv7;
    logic       rdy8, rdy7;
    logic       par_en, par_type, stop2;
    logic [5:0] prescale;
    logic       tx8, tx7, busy8, busy7, fd8, fd7;
    logic       sel;

    logic       tx_s, busy_s, fd_s, rdy_s;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_gen2 #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut8 (
        .clk(clk_tb), .rst(rst), .p_data(p8), .data_valid(dv8),
        .data_ready(rdy8), .par_en(par_en), .par_type(par_type),
        .stop2(stop2), .prescale(prescale), .tx_out(tx8), .busy(busy8),
        .frame_done(fd8)
    );

    uart_tx_gen2 #(.DATA_WIDTH(7), .PRESC_WIDTH(6)) dut7 (
        .clk(clk_tb), .rst(rst), .p_data(p7), .data_valid(dv7),
        .data_ready(rdy7), .par_en(par_en), .par_type(par_type),
        .stop2(stop2), .prescale(prescale), .tx_out(tx7), .busy(busy7),
        .frame_done(fd7)
    );

    assign tx_s   = sel ? tx7   : tx8;
    assign busy_s = sel ? busy7 : busy8;
    assign fd_s   = sel ? fd7   : fd8;
    assign rdy_s  = sel ? rdy7  : rdy8;

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Offer a word to an idle DUT and check accept and START latency.
    task automatic send(input logic [8:0] d);
        if (sel) begin dv7 = 1'b1; p7 = d[6:0]; end
        else     begin dv8 = 1'b1; p8 = d[7:0]; end
        check("ready_before_accept", 4'(rdy_s), 4'h1);
        tick();
        dv7 = 1'b0;
        dv8 = 1'b0;
        check("after_accept_rdy_busy_tx", 4'({rdy_s, busy_s, tx_s}), 4'b0001);
        tick();
        check("start_rdy_busy_tx", 4'({rdy_s, busy_s, tx_s}), 4'b0110);
    endtask

    // Check line bits, busy and frame_done from sample index skip onward.
    // exp holds the frame with the first transmitted bit in the MSB position.
    task automatic run_frame(input logic [15:0] exp, input int nbits, input int per, input int skip);
        logic e;
        int   i;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < per; c++) begin
                i = b * per + c;
                if (i >= skip) begin
                    e = exp[4'(nbits - 1 - b)];
                    if (i == 0)
                        check("frame_busy_tx", 4'({busy_s, tx_s}), 4'({1'b1, e}));
                    else
                        check("frame_busy_tx_fd", 4'({busy_s, tx_s, fd_s}), 4'({1'b1, e, 1'b0}));
                    tick();
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0;
        p8 = '0; p7 = '0; dv8 = 1'b0; dv7 = 1'b0;
        par_en = 1'b1; par_type = 1'b0; stop2 = 1'b0; prescale = 6'd0;
        tick(); tick();
        check("reset8_tx_busy_fd_rdy", 4'({tx8, busy8, fd8, rdy8}), 4'b1001);
        check("reset7_tx_busy_fd_rdy", 4'({tx7, busy7, fd7, rdy7}), 4'b1001);
        rst = 1'b1;
        tick();
        check("idle_after_reset", 4'({tx8, busy8, fd8, rdy8}), 4'b1001);

        // 0xA5, even parity, one stop, 1 clk per bit
        send(9'h0A5);
        run_frame(16'(11'b01010010101), 11, 1, 0);
        check("t1_end_fd_busy_tx", 4'({fd_s, busy_s, tx_s}), 4'b101);
        tick();
        check("t1_fd_single", 4'({fd_s, busy_s, tx_s}), 4'b001);

        // 0x3C, odd parity, two stops, 4 clk per bit; config changed mid-frame
        prescale = 6'd3; par_type = 1'b1; stop2 = 1'b1;
        send(9'h03C);
        prescale = 6'd0; par_type = 1'b0; stop2 = 1'b0;
        run_frame(16'(12'b000111100111), 12, 4, 0);
        check("t2_end_fd_busy_tx", 4'({fd_s, busy_s, tx_s}), 4'b101);
        tick();
        check("t2_fd_single", 4'(fd_s), 4'h0);

        // Back-to-back 0x55 then 0x0F
        send(9'h055);
        dv8 = 1'b1; p8 = 8'h0F;
        tick();
        dv8 = 1'b0;
        check("t3_hold_full_rdy", 4'(rdy_s), 4'h0);
        run_frame(16'(11'b01010101001), 11, 1, 1);
        check("t3_b2b_fd_busy_tx_rdy", 4'({fd_s, busy_s, tx_s, rdy_s}), 4'b1101);
        run_frame(16'(11'b01111000001), 11, 1, 0);
        check("t3_end2_fd_busy_tx", 4'({fd_s, busy_s, tx_s}), 4'b101);
        tick();

        // 7-bit instance, no parity, 0x41
        sel = 1'b1; par_en = 1'b0;
        send(9'h041);
        run_frame(16'(9'b010000011), 9, 1, 0);
        check("t4_end_fd_busy_tx", 4'({fd_s, busy_s, tx_s}), 4'b101);
        tick();
        check("t4_dut8_quiet", 4'({tx8, busy8, fd8}), 4'b100);
        sel = 1'b0; par_en = 1'b1;

        // Third word offered while holding register is full is ignored
        send(9'h033);
        dv8 = 1'b1; p8 = 8'hCC;
        tick();
        dv8 = 1'b0;
        check("t5_full_rdy", 4'(rdy_s), 4'h0);
        dv8 = 1'b1; p8 = 8'hFF;
        tick();
        dv8 = 1'b0;
        check("t5_still_full_rdy", 4'(rdy_s), 4'h0);
        run_frame(16'(11'b01100110001), 11, 1, 2);
        check("t5_b2b_fd_busy_tx_rdy", 4'({fd_s, busy_s, tx_s, rdy_s}), 4'b1101);
        run_frame(16'(11'b00011001101), 11, 1, 0);
        check("t5_end2_fd_busy_tx", 4'({fd_s, busy_s, tx_s}), 4'b101);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t5_no_third_frame", 4'({busy_s, tx_s, fd_s, rdy_s}), 4'b0101);
        end

        // Reset during data bit 3 of 0x00, then 0xFF
        send(9'h000);
        tick(); tick(); tick(); tick();
        check("t6_bit3_busy_tx", 4'({busy_s, tx_s}), 4'b10);
        #2 rst = 1'b0;
        #1;
        check("t6_async_reset", 4'({tx_s, busy_s, fd_s, rdy_s}), 4'b1001);
        tick(); tick();
        check("t6_held_reset", 4'({tx_s, busy_s, fd_s, rdy_s}), 4'b1001);
        rst = 1'b1;
        tick();
        check("t6_idle_after_release", 4'({tx_s, busy_s, fd_s, rdy_s}), 4'b1001);
        send(9'h0FF);
        run_frame(16'(11'b01111111101), 11, 1, 0);
        check("t6_end_fd_busy_tx", 4'({fd_s, busy_s, tx_s}), 4'b101);
        tick();
        check("t6_fd_single", 4'(fd_s), 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_gen2.md
Name: uart_tx_gen2

Overview:
Parametrised next-generation UART transmitter. It serialises DATA_WIDTH-bit words into start / data (LSB first) / optional parity / 1-or-2 stop bit frames. The bit period is programmable through a prescaler. A one-deep holding register with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the system-side data producer and the serial line, and replaces the fixed 8-bit, one-clock-per-bit transmitter.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESC_WIDTH, 6, width of the prescale input.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
p_data  input  DATA_WIDTH  word to send; valid when data_valid=1.
data_valid  input  1  producer offers p_data.
data_ready  output  1  holding register empty; a word is accepted on a clk edge where data_valid & data_ready.
par_en  input  1  1 = insert parity bit.
par_type  input  1  0 = even, 1 = odd parity.
stop2  input  1  1 = two stop bits, 0 = one.
prescale  input  PRESC_WIDTH  bit period = prescale+1 clk cycles.
tx_out  output  1  serial line; idles high.
busy  output  1  high while a frame is on the line.
frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_out=1, busy=0, frame_done=0, data_ready=1.
  - Holding register empty; FSM in IDLE; all counters 0.
  - Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- Holding register (hold_full flag):
  - data_ready = ~hold_full.
  - On an accept edge, p_data is stored and hold_full is set.
  - hold_full clears on the edge where the FSM enters START and loads the shift register.
  - No bypass: when hold_full=1, data_ready=0 for that whole cycle, even if the word moves out that edge.
  - data_valid while data_ready=0 is ignored; the producer must hold it.
- Configuration latch: par_en, par_type, stop2 and prescale are sampled on the edge entering START and held for the whole frame. Changes mid-frame do not affect the current frame.
- Parity: computed from the latched data word. Even gives ^data; odd gives ~^data.
- FSM states, all outputs registered:
  - IDLE: tx_out=1, busy=0. If hold_full, go to START on the next edge.
  - START: tx_out=0 for one bit period.
  - DATA: data[0]..data[DATA_WIDTH-1], one bit period each; a bit counter counts 0..DATA_WIDTH-1.
  - PARITY (only if par_en latched): one bit period.
  - STOP: tx_out=1 for 1 or 2 bit periods.
- Bit timing: a prescale counter counts 0..P, where P is the latched prescale. The state or bit advances on the edge where the counter equals P; the counter then wraps to 0. prescale=0 gives 1 clk per bit.
- busy rises on the same edge tx_out goes low for START. It stays high through the last stop bit period.
- Latency: accept at edge k with the FSM idle gives hold_full after k; START (tx_out=0, busy=1) after edge k+1.
- End of the last stop bit:
  - frame_done=1 for exactly one cycle following that edge.
  - If hold_full, go directly to START on that same edge: no idle cycle, busy stays 1, and frame_done still pulses.
  - Otherwise go to IDLE with busy=0.
- Frame length: (2 + DATA_WIDTH + par_en + stop2) bits × (prescale+1) clk.

Test Plan:
1. DW=8, prescale=0, par_en=1, par_type=0, stop2=0; send 0xA5.
   -> tx_out = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; busy high 11 cycles; a single frame_done pulse; data_ready low 1 cycle.
2. prescale=3, par_type=1, stop2=1; send 0x3C.
   -> each bit held 4 clk; odd parity bit = 1; 12 bits = 48 cycles of busy; two stop bits high.
3. prescale=0; send 0x55, then 0x0F on the cycle data_ready returns high.
   -> second START immediately follows the first stop bit; busy high 22 contiguous cycles; two frame_done pulses, 11 cycles apart.
4. Instance DATA_WIDTH=7, par_en=0; send 0x41.
   -> 9-bit frame 0,1,0,0,0,0,0,1,1.
5. Hold register full (frame running, second word pending); pulse a third data_valid with data_ready=0.
   -> third word not transmitted; only two frames appear.
6. Drive rst=0 during data bit 3 of a 0x00 frame.
   -> tx_out=1, busy=0, data_ready=1 asynchronously. After release, sending 0xFF gives a correct full frame (even parity 0).
